// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned WORD_BYTES = 4;

  // One buffered fetch result: the PC it was fetched from and the raw word.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  // IDLE holds off the first request for one edge after reset release.
  typedef enum logic {
    FS_IDLE = 1'b0,
    FS_RUN  = 1'b1
  } fetch_state_e;

  // Sequential successor of a fetch address, wrapping modulo 2^32.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return 32'(pc + 32'(WORD_BYTES));
  endfunction

  // Force a redirect target onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] a);
    return a & ~32'(WORD_BYTES - 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; pushing and popping the only entry in one
// cycle leaves the new entry at the head.
module sync_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = ENTRY_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the queue at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      if (do_pop)  rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      case ({do_push, do_pop})
        2'b10:   count <= CNT_W'(count + 1'b1);
        2'b01:   count <= CNT_W'(count - 1'b1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    (push && !flush) |-> !full);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: sequential word reads under a credit limit, in-order
// responses buffered for decode, redirect flushes buffered and in-flight work.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] PC_INIT         = 32'h8000_0000,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING + 1);

  fetch_state_e     state, state_n;
  logic [31:0]      fetch_pc, fetch_pc_n;
  logic [31:0]      resp_pc, resp_pc_n;
  logic [OUT_W-1:0] live, live_n;
  logic [OUT_W-1:0] discard, discard_n;

  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_flush;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

  logic             credit_ok;
  logic             req_fire;
  logic             rsp_keep;
  logic             rsp_drop;

  // Room for every live request in the FIFO and under the in-flight cap.
  assign credit_ok = (32'(fifo_count) + 32'(live) < 32'(DEPTH)) &&
                     (32'(live) + 32'(discard) < 32'(MAX_OUTSTANDING));

  assign mem_req_valid = (state == FS_RUN) && !redirect_valid && credit_ok;
  assign mem_req_addr  = fetch_pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  // Responses owed to pre-redirect requests are always the oldest ones.
  assign rsp_keep = mem_rsp_valid && !redirect_valid && (discard == '0);
  assign rsp_drop = mem_rsp_valid && !redirect_valid && (discard != '0);

  assign push_entry = '{pc: resp_pc, instr: mem_rsp_data};

  // Next-state for the run state, PCs and the live/discard counters.
  always_comb begin
    state_n    = FS_RUN;
    fetch_pc_n = fetch_pc;
    resp_pc_n  = resp_pc;
    live_n     = live;
    discard_n  = discard;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;

    if (redirect_valid) begin
      // Everything still in flight becomes debt; a response this cycle pays one.
      fifo_flush = 1'b1;
      fetch_pc_n = align_word(redirect_pc);
      resp_pc_n  = align_word(redirect_pc);
      discard_n  = OUT_W'(32'(discard) + 32'(live) - 32'(mem_rsp_valid));
      live_n     = '0;
    end else begin
      if (req_fire) fetch_pc_n = next_pc(fetch_pc);
      if (rsp_keep) begin
        fifo_push = 1'b1;
        resp_pc_n = next_pc(resp_pc);
      end
      if (rsp_drop) discard_n = OUT_W'(discard - 1'b1);
      live_n = OUT_W'(32'(live) + 32'(req_fire) - 32'(rsp_keep));
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FS_IDLE;
      fetch_pc <= PC_INIT;
      resp_pc  <= PC_INIT;
      live     <= '0;
      discard  <= '0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      resp_pc  <= resp_pc_n;
      live     <= live_n;
      discard  <= discard_n;
    end
  end

  assign fifo_pop = instr_valid && instr_ready;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .wdata (push_entry),
    .rdata (head_entry),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign instr_valid = !fifo_empty;
  assign instr_data  = head_entry.instr;
  assign instr_pc    = head_entry.pc;

  a_outstanding_cap: assert property (@(posedge clk) disable iff (rst)
    (32'(live) + 32'(discard) <= 32'(MAX_OUTSTANDING)));

  a_rsp_has_owner: assert property (@(posedge clk) disable iff (rst)
    mem_rsp_valid |-> ((live != '0) || (discard != '0)));

  a_push_has_room: assert property (@(posedge clk) disable iff (rst)
    rsp_keep |-> !fifo_full);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small in-order memory model.
module tb_fetch_unit;

  localparam logic [31:0] PC_INIT = 32'h8000_0000;
  localparam logic [31:0] KEY     = 32'h5A5A_1234;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          cyc = 0;
  int          lat = 1;
  bit          rand_ready = 1'b0;
  bit          rand_iready = 1'b0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_out = 0;
  int          mark = 0;
  logic [31:0] exp_req_pc = PC_INIT;
  logic [31:0] exp_out_pc = PC_INIT;
  logic [31:0] last_pc = '0;
  logic [31:0] last_data = '0;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Sample one cycle's handshakes and compare against the expected stream.
  task automatic observe();
    if (redirect_valid) check("req_blocked_on_redirect", 32'(mem_req_valid), 32'd0);
    if (mem_rsp_valid) void'(mq.pop_front());
    if (mem_req_valid && mem_req_ready) begin
      check("req_addr", mem_req_addr, exp_req_pc);
      exp_req_pc = 32'(exp_req_pc + 32'd4);
      mq.push_back('{addr: mem_req_addr, due: cyc + lat});
    end
    if (instr_valid && instr_ready) begin
      check("out_pc", instr_pc, exp_out_pc);
      check("out_data", instr_data, mdata(exp_out_pc));
      last_pc    = instr_pc;
      last_data  = instr_data;
      exp_out_pc = 32'(exp_out_pc + 32'd4);
      n_out++;
    end
    if (redirect_valid) begin
      exp_req_pc = redirect_pc & ~32'h3;
      exp_out_pc = redirect_pc & ~32'h3;
    end
    check("outstanding_cap", 32'(mq.size() <= 2), 32'd1);
  endtask

  // One clock: drive memory/random inputs at negedge, observe, then advance.
  task automatic step();
    @(negedge clk);
    if (rand_ready)  mem_req_ready = 1'($urandom_range(0, 1));
    if (rand_iready) instr_ready   = 1'($urandom_range(0, 1));
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mdata(mq[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'hDEAD_BEEF;
    end
    #1;
    observe();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    mem_rsp_valid  = 1'b0;
    mq.delete();
    @(posedge clk);
    #1;
    rst        = 1'b0;
    exp_req_pc = PC_INIT;
    exp_out_pc = PC_INIT;
  endtask

  task automatic wait_head(input string tag);
    instr_ready = 1'b0;
    for (int i = 0; i < 40 && !instr_valid; i++) step();
    check({tag, "_valid"}, 32'(instr_valid), 32'd1);
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    mem_req_ready  = 1'b1;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = '0;
    instr_ready    = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset values.
    #12;
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_req_addr", mem_req_addr, PC_INIT);
    check("rst_instr_data", instr_data, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);

    // Streaming at 1-cycle latency; first request after the first edge.
    do_reset();
    check("idle_before_edge", 32'(mem_req_valid), 32'd0);
    step();
    check("first_req_valid", 32'(mem_req_valid), 32'd1);
    check("first_req_addr", mem_req_addr, PC_INIT);
    repeat (3) step();
    check("first_out_count", 32'(n_out), 32'd1);
    check("first_out_pc", last_pc, 32'h8000_0000);
    check("first_out_data", last_data, 32'hDA5A_1234);
    repeat (10) step();
    check("stream_no_gaps", 32'(n_out), 32'd11);

    // Decode stall fills exactly DEPTH entries, then drains in order.
    instr_ready = 1'b0;
    do_reset();
    repeat (12) step();
    check("stall_head_pc", instr_pc, 32'h8000_0000);
    check("stall_req_valid", 32'(mem_req_valid), 32'd0);
    check("stall_inflight", 32'(mq.size()), 32'd0);
    check("stall_next_addr", mem_req_addr, 32'h8000_0010);
    instr_ready = 1'b1;
    mark = n_out;
    repeat (8) step();
    check("drain_count", 32'(n_out - mark), 32'd8);
    check("drain_last_pc", last_pc, 32'h8000_001C);

    // Redirect with two requests in flight at latency 3.
    lat = 3;
    do_reset();
    for (int i = 0; i < 10 && mq.size() != 2; i++) step();
    check("two_in_flight", 32'(mq.size()), 32'd2);
    do_redirect(32'h0000_1002);
    check("redir_addr", mem_req_addr, 32'h0000_1000);
    wait_head("redir_head");
    check("redir_head_pc", instr_pc, 32'h0000_1000);
    check("redir_head_data", instr_data, 32'h5A5A_0234);
    instr_ready = 1'b1;
    repeat (6) step();

    // Redirect coinciding with a response, then a second redirect.
    lat = 2;
    do_reset();
    repeat (6) step();
    for (int i = 0; i < 20 && !(mq.size() == 2 && mq[0].due <= cyc); i++) step();
    check("rsp_due_at_redirect", 32'(mq.size() == 2 && mq[0].due <= cyc), 32'd1);
    do_redirect(32'h0000_2000);
    do_redirect(32'h0000_3000);
    wait_head("dbl_head");
    check("dbl_head_pc", instr_pc, 32'h0000_3000);
    check("dbl_head_data", instr_data, 32'h5A5A_2234);
    instr_ready = 1'b1;
    repeat (8) step();

    // Random memory and decode backpressure at latency 3.
    lat = 3;
    do_reset();
    rand_ready  = 1'b1;
    rand_iready = 1'b1;
    mark = n_out;
    repeat (300) step();
    rand_ready    = 1'b0;
    rand_iready   = 1'b0;
    mem_req_ready = 1'b1;
    instr_ready   = 1'b1;
    repeat (20) step();
    check("rand_progress", 32'((n_out - mark) > 20), 32'd1);

    // Address wrap from the top of the address space.
    lat = 1;
    do_redirect(32'hFFFF_FFFC);
    wait_head("wrap_top");
    check("wrap_top_pc", instr_pc, 32'hFFFF_FFFC);
    check("wrap_top_data", instr_data, 32'hA5A5_EDC8);
    instr_ready = 1'b1;
    step();
    wait_head("wrap_zero");
    check("wrap_zero_pc", instr_pc, 32'h0000_0000);
    check("wrap_zero_data", instr_data, 32'h5A5A_1234);
    instr_ready = 1'b1;
    repeat (6) step();

    // Reset asserted mid-stream clears outputs without waiting for a clock.
    #2;
    rst = 1'b1;
    #1;
    check("midrst_instr_valid", 32'(instr_valid), 32'd0);
    check("midrst_req_valid", 32'(mem_req_valid), 32'd0);
    check("midrst_req_addr", mem_req_addr, PC_INIT);
    check("midrst_instr_pc", instr_pc, 32'd0);
    do_reset();
    step();
    check("post_rst_req_valid", 32'(mem_req_valid), 32'd1);
    check("post_rst_req_addr", mem_req_addr, PC_INIT);
    mark = n_out;
    repeat (10) step();
    check("post_rst_outputs", 32'(n_out - mark), 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
